// File: rtl/avalon_mm_multi_master.sv
// Multi-channel Avalon-MM master. Several independent requesters each own a
// one-entry request buffer; an arbiter (round-robin or fixed priority) picks one
// pending request at a time and drives it onto a single Avalon-MM master port.
// Supports bus locking by one channel and an optional wait-request timeout.
module avalon_mm_multi_master #(
  parameter int CHANNELS      = 3,
  parameter int WIDTH         = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [CHANNELS-1:0]            start,
  input  logic [CHANNELS-1:0]            rnw,
  input  logic [CHANNELS-1:0]            lock_req,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] address_to_access,
  input  logic [CHANNELS*WIDTH-1:0]      data_to_write,
  output logic [CHANNELS-1:0]            busy,
  output logic [CHANNELS-1:0]            done,
  output logic [CHANNELS-1:0]            err,
  output logic [WIDTH-1:0]               data_read,
  output logic [ADDR_WIDTH-1:0]          ADDRESS,
  output logic                           BEGINTRANSFER,
  output logic                           READ,
  output logic                           WRITE,
  output logic [WIDTH-1:0]               WRITEDATA,
  output logic                           LOCK,
  input  logic [WIDTH-1:0]               READDATA,
  input  logic                           WAITREQUEST
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Counter only has to reach TIMEOUT-1.
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  // Control state
  logic [0:0]                           state_q, state_d;
  logic [CHANNELS-1:0]                  pend_q, pend_d;
  logic [IDX_W-1:0]                     gnt_q, gnt_d;
  logic [IDX_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                     owner_q, owner_d;
  logic                                 owner_vld_q, owner_vld_d;
  logic [TO_W-1:0]                      wait_cnt_q, wait_cnt_d;
  logic [CHANNELS-1:0]                  done_q, done_d;
  logic [CHANNELS-1:0]                  err_q, err_d;

  // Bus-facing and result registers
  logic [WIDTH-1:0]                     data_read_q, data_read_d;
  logic [ADDR_WIDTH-1:0]                address_q, address_d;
  logic [WIDTH-1:0]                     writedata_q, writedata_d;
  logic                                 read_q, read_d;
  logic                                 write_q, write_d;
  logic                                 lock_q, lock_d;
  logic                                 bt_q, bt_d;

  // Per-channel request buffers (data only, no reset needed)
  logic [CHANNELS-1:0]                  rnw_buf_q, rnw_buf_d;
  logic [CHANNELS-1:0]                  lock_buf_q, lock_buf_d;
  logic [CHANNELS-1:0][ADDR_WIDTH-1:0]  addr_buf_q, addr_buf_d;
  logic [CHANNELS-1:0][WIDTH-1:0]       wdata_buf_q, wdata_buf_d;

  // Arbiter results
  logic [CHANNELS-1:0]                  elig;
  logic                                 gnt_vld;
  logic [IDX_W-1:0]                     gnt_sel;

  // Round-robin candidate k positions after the pointer, with wrap-around.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr, input int k);
    int sum;
    sum = (int'(ptr) + k) % CHANNELS;
    return sum[IDX_W-1:0];
  endfunction

  // A channel is busy while its request waits in the buffer or is on the bus.
  always_comb begin
    busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = pend_q[i] | ((state_q == S_XFER) && (gnt_q == IDX_W'(i)));
    end
  end

  // Eligibility and grant selection; a lock owner excludes everyone else.
  always_comb begin
    elig    = '0;
    gnt_vld = 1'b0;
    gnt_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      elig[i] = pend_q[i] && (!owner_vld_q || (owner_q == IDX_W'(i)));
    end
    // Loops run from lowest to highest preference so the last hit wins.
    if (PRIORITY_MODE != 0) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (elig[i]) begin
          gnt_vld = 1'b1;
          gnt_sel = IDX_W'(i);
        end
      end
    end else begin
      for (int k = CHANNELS; k >= 1; k--) begin
        if (elig[rr_idx(rr_ptr_q, k)]) begin
          gnt_vld = 1'b1;
          gnt_sel = rr_idx(rr_ptr_q, k);
        end
      end
    end
  end

  // Request capture, grant and transfer sequencing.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    wait_cnt_d  = wait_cnt_q;
    done_d      = '0;
    err_d       = '0;
    data_read_d = data_read_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    read_d      = read_q;
    write_d     = write_q;
    lock_d      = lock_q;
    bt_d        = 1'b0;
    rnw_buf_d   = rnw_buf_q;
    lock_buf_d  = lock_buf_q;
    addr_buf_d  = addr_buf_q;
    wdata_buf_d = wdata_buf_q;

    for (int i = 0; i < CHANNELS; i++) begin
      if (start[i] && !busy[i]) begin
        pend_d[i]      = 1'b1;
        rnw_buf_d[i]   = rnw[i];
        lock_buf_d[i]  = lock_req[i];
        addr_buf_d[i]  = address_to_access[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_buf_d[i] = data_to_write[i*WIDTH +: WIDTH];
      end
    end

    case (state_q)
      S_IDLE: begin
        // The done cycle is a turnaround cycle: a channel re-requesting on its
        // done pulse competes in the following arbitration.
        if (gnt_vld && (done_q == '0)) begin
          pend_d[gnt_sel] = 1'b0;
          gnt_d           = gnt_sel;
          if (PRIORITY_MODE == 0) begin
            rr_ptr_d = gnt_sel;
          end
          address_d   = addr_buf_q[gnt_sel];
          read_d      = rnw_buf_q[gnt_sel];
          write_d     = !rnw_buf_q[gnt_sel];
          writedata_d = rnw_buf_q[gnt_sel] ? '0 : wdata_buf_q[gnt_sel];
          lock_d      = lock_buf_q[gnt_sel];
          bt_d        = 1'b1;
          wait_cnt_d  = '0;
          if (lock_buf_q[gnt_sel]) begin
            owner_vld_d = 1'b1;
            owner_d     = gnt_sel;
          end
          state_d = S_XFER;
        end
      end
      default: begin
        if (!WAITREQUEST) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          lock_d  = 1'b0;
          if (read_q) begin
            data_read_d = READDATA;
          end
          done_d[gnt_q] = 1'b1;
          // An unlocked transfer by the owner releases the bus lock.
          if (!lock_q) begin
            owner_vld_d = 1'b0;
          end
          state_d = S_IDLE;
        end else if ((TIMEOUT > 0) && (wait_cnt_q == TO_W'(TIMEOUT - 1))) begin
          read_d        = 1'b0;
          write_d       = 1'b0;
          lock_d        = 1'b0;
          data_read_d   = '0;
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = 1'b1;
          owner_vld_d   = 1'b0;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      gnt_q       <= '0;
      rr_ptr_q    <= IDX_W'(CHANNELS - 1);
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      wait_cnt_q  <= '0;
      done_q      <= '0;
      err_q       <= '0;
      data_read_q <= '0;
      address_q   <= '0;
      writedata_q <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      lock_q      <= 1'b0;
      bt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      wait_cnt_q  <= wait_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      data_read_q <= data_read_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      read_q      <= read_d;
      write_q     <= write_d;
      lock_q      <= lock_d;
      bt_q        <= bt_d;
    end
  end

  // Request buffer contents; only meaningful while the pending bit is set.
  always_ff @(posedge CLK) begin
    rnw_buf_q   <= rnw_buf_d;
    lock_buf_q  <= lock_buf_d;
    addr_buf_q  <= addr_buf_d;
    wdata_buf_q <= wdata_buf_d;
  end

  assign done          = done_q;
  assign err           = err_q;
  assign data_read     = data_read_q;
  assign ADDRESS       = address_q;
  assign BEGINTRANSFER = bt_q;
  assign READ          = read_q;
  assign WRITE         = write_q;
  assign WRITEDATA     = writedata_q;
  assign LOCK          = lock_q;

endmodule

// File: tb/tb_avalon_mm_multi_master.sv
// Testbench for avalon_mm_multi_master: a round-robin instance with an 8-cycle
// timeout and a fixed-priority instance, a simple Avalon slave model and a
// scoreboard of expected per-channel completions.
module tb_avalon_mm_multi_master;

  logic clk;
  logic rst;

  // Instance A: round-robin, TIMEOUT = 8
  logic [2:0]  start, rnw, lock_req;
  logic [95:0] address_to_access, data_to_write;
  logic [2:0]  busy, done, err;
  logic [31:0] data_read, ADDRESS, WRITEDATA, READDATA;
  logic        BEGINTRANSFER, READ, WRITE, LOCK, WAITREQUEST;

  // Instance B: fixed priority, no timeout
  logic [2:0]  start_b, rnw_b, lock_req_b;
  logic [95:0] addr_b, wdata_b;
  logic [2:0]  busy_b, done_b, err_b;
  logic [31:0] data_read_b, address_bus_b, writedata_bus_b, readdata_b;
  logic        bt_b, read_b, write_b, lock_b, waitreq_b;

  avalon_mm_multi_master #(.CHANNELS(3), .WIDTH(32), .ADDR_WIDTH(32),
                           .PRIORITY_MODE(0), .TIMEOUT(8)) dut_a (
    .CLK(clk), .RST(rst), .start(start), .rnw(rnw), .lock_req(lock_req),
    .address_to_access(address_to_access), .data_to_write(data_to_write),
    .busy(busy), .done(done), .err(err), .data_read(data_read),
    .ADDRESS(ADDRESS), .BEGINTRANSFER(BEGINTRANSFER), .READ(READ), .WRITE(WRITE),
    .WRITEDATA(WRITEDATA), .LOCK(LOCK), .READDATA(READDATA), .WAITREQUEST(WAITREQUEST)
  );

  avalon_mm_multi_master #(.CHANNELS(3), .WIDTH(32), .ADDR_WIDTH(32),
                           .PRIORITY_MODE(1), .TIMEOUT(0)) dut_b (
    .CLK(clk), .RST(rst), .start(start_b), .rnw(rnw_b), .lock_req(lock_req_b),
    .address_to_access(addr_b), .data_to_write(wdata_b),
    .busy(busy_b), .done(done_b), .err(err_b), .data_read(data_read_b),
    .ADDRESS(address_bus_b), .BEGINTRANSFER(bt_b), .READ(read_b), .WRITE(write_b),
    .WRITEDATA(writedata_bus_b), .LOCK(lock_b), .READDATA(readdata_b), .WAITREQUEST(waitreq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    bit          rd;
    bit          lk;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdat;
    bit          er;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   done_log[$];
  int   b_log[$];
  int   exp_b[6] = '{0, 0, 0, 0, 1, 2};

  int n_chk = 0;
  int n_err = 0;

  // Slave model configuration
  int          ws_cfg   = 0;
  bit          stuck_en = 1'b0;
  logic [31:0] rd_val   = 32'h0;
  int          wcnt     = 0;

  // Captured at BEGINTRANSFER, compared at done
  logic [31:0] cur_addr, cur_wd;
  logic        cur_rd, cur_wr, cur_lk;
  int          xfer_len = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start   = '0;
    start_b = '0;
  endtask

  task automatic issue(input int ch, input bit rd, input bit lk, input logic [31:0] addr,
                       input logic [31:0] wd, input bit er, input int len);
    exp_t e;
    start[ch]                      = 1'b1;
    rnw[ch]                        = rd;
    lock_req[ch]                   = lk;
    address_to_access[ch*32 +: 32] = addr;
    data_to_write[ch*32 +: 32]     = wd;
    e.ch   = ch;
    e.rd   = rd;
    e.lk   = lk;
    e.addr = addr;
    e.wd   = rd ? 32'h0 : wd;
    e.rdat = er ? 32'h0 : rd_val;
    e.er   = er;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic wait_dones(input int n, input int budget);
    for (int i = 0; i < budget && done_log.size() < n; i++) tick();
    chk("wait_done", done_log.size(), n);
  endtask

  task automatic wait_bt(input string tag);
    for (int i = 0; i < 12 && !BEGINTRANSFER; i++) tick();
    chk(tag, BEGINTRANSFER, 1);
  endtask

  task automatic single_read();
    rd_val = 32'hDEADBEEF;
    issue(1, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 1);
    tick();
    chk("s1_busy_c1", busy[1], 1);
    chk("s1_read_c1", READ, 0);
    tick();
    chk("s1_read_c2", READ, 1);
    chk("s1_bt_c2", BEGINTRANSFER, 1);
    chk("s1_addr_c2", ADDRESS, 32'h1000);
    tick();
    chk("s1_done_c3", done, 3'b010);
    chk("s1_err_c3", err, 3'b000);
    chk("s1_data_c3", data_read, 32'hDEADBEEF);
    chk("s1_read_c3", READ, 0);
    tick();
  endtask

  // Bus monitor, scoreboard compare and slave response, all on the falling edge.
  always @(negedge clk) begin : mon
    int ch;
    int idx;
    exp_t e;
    if (rst) begin
      xfer_len    = 0;
      wcnt        = 0;
      WAITREQUEST = 1'b0;
    end else begin
      if (BEGINTRANSFER) begin
        cur_addr = ADDRESS;
        cur_wd   = WRITEDATA;
        cur_rd   = READ;
        cur_wr   = WRITE;
        cur_lk   = LOCK;
        xfer_len = 0;
      end
      if (READ || WRITE) xfer_len++;
      if (done != 3'b000) begin
        chk("done_onehot", $countones(done), 1);
        ch = -1;
        for (int i = 0; i < 3; i++) if (done[i]) ch = i;
        idx = -1;
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].ch == ch) idx = i;
        chk("sb_match", idx >= 0, 1);
        if (idx >= 0) begin
          e = sb[idx];
          sb.delete(idx);
          chk("sb_err", err[ch], e.er);
          chk("sb_rd", cur_rd, e.rd);
          chk("sb_wr", cur_wr, !e.rd);
          chk("sb_addr", cur_addr, e.addr);
          chk("sb_wdata", cur_wd, e.wd);
          chk("sb_lock", cur_lk, e.lk);
          chk("sb_len", xfer_len, e.len);
          chk("sb_busy_clr", busy[ch], 0);
          if (e.rd) chk("sb_rdata", data_read, e.rdat);
        end
        done_log.push_back(ch);
      end
      if (BEGINTRANSFER) wcnt = 0;
      else if (READ || WRITE) wcnt++;
      WAITREQUEST = (READ || WRITE) &&
                    ((stuck_en && ADDRESS == 32'hBAD0) || (wcnt < ws_cfg));
      READDATA = rd_val;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cyc, bt_cyc, bad, last_wr, done_at, restarts;
    rst = 1'b1;
    start = '0; rnw = '0; lock_req = '0; address_to_access = '0; data_to_write = '0;
    start_b = '0; rnw_b = '0; lock_req_b = '0; addr_b = '0; wdata_b = '0;
    readdata_b = 32'h0; waitreq_b = 1'b0;
    READDATA = 32'h0; WAITREQUEST = 1'b0;
    repeat (3) tick();
    chk("rst_ctl", {READ, WRITE, BEGINTRANSFER, LOCK, done, err, busy}, 0);
    chk("rst_addr", ADDRESS, 0);
    chk("rst_data", data_read, 0);
    rst = 1'b0;
    tick();

    // Round-robin fairness: three simultaneous writes, three rounds
    done_log.delete();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) issue(c, 1'b0, 1'b0, 32'h100 + 32'(c), 32'hA000 + 32'(r*3 + c), 1'b0, 1);
      tick();
      wait_dones(3 * (r + 1), 40);
    end
    for (int k = 0; k < 9; k++) if (k < done_log.size()) chk("rr_order", done_log[k], k % 3);

    // Single zero-wait read
    single_read();

    // Wait states with an ignored start while busy
    ws_cfg = 4;
    issue(1, 1'b0, 1'b0, 32'h20, 32'h55AA, 1'b0, 5);
    tick();
    wr_cyc = 0; bt_cyc = 0; bad = 0; last_wr = -1; done_at = -1;
    for (int i = 0; i < 30 && done_at < 0; i++) begin
      if (WRITE) begin
        wr_cyc++;
        last_wr = i;
        if (ADDRESS != 32'h20 || WRITEDATA != 32'h55AA) bad++;
      end
      if (BEGINTRANSFER) bt_cyc++;
      if (done[1]) done_at = i;
      if (i == 2) begin
        start[1] = 1'b1; rnw[1] = 1'b1; address_to_access[32 +: 32] = 32'h999;
      end
      tick();
    end
    chk("ws_write_cycles", wr_cyc, 5);
    chk("ws_bt_cycles", bt_cyc, 1);
    chk("ws_stable", bad, 0);
    chk("ws_done_at", done_at, last_wr + 1);
    chk("ws_dr_hold", data_read, 32'hDEADBEEF);
    ws_cfg = 0;
    repeat (3) tick();

    // Lock: ch2 locked write, ch0 blocked until ch2's unlocked read
    done_log.delete();
    issue(2, 1'b0, 1'b1, 32'h300, 32'h1111, 1'b0, 1);
    tick();
    wait_bt("lk_bt");
    chk("lk_lock", LOCK, 1);
    issue(0, 1'b0, 1'b0, 32'h400, 32'h2222, 1'b0, 1);
    tick();
    wait_dones(1, 20);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lk_block_bt", BEGINTRANSFER, 0);
      chk("lk_ch0_busy", busy[0], 1);
    end
    rd_val = 32'hCAFE0001;
    issue(2, 1'b1, 1'b0, 32'h304, 32'h0, 1'b0, 1);
    tick();
    wait_dones(3, 30);
    for (int k = 0; k < 3; k++) if (k < done_log.size()) chk("lk_order", done_log[k], (k < 2) ? 2 : 0);

    // Timeout: ch0 read stuck, ch1 write served afterwards
    stuck_en = 1'b1;
    done_log.delete();
    issue(0, 1'b1, 1'b0, 32'hBAD0, 32'h0, 1'b1, 8);
    tick();
    wait_bt("to_bt");
    issue(1, 1'b0, 1'b0, 32'h500, 32'h3333, 1'b0, 1);
    tick();
    wait_dones(2, 40);
    for (int k = 0; k < 2; k++) if (k < done_log.size()) chk("to_order", done_log[k], k);
    chk("to_dr_zero", data_read, 0);

    // Reset in the middle of a stuck transfer
    start[1] = 1'b1; rnw[1] = 1'b1; lock_req[1] = 1'b0;
    address_to_access[32 +: 32] = 32'hBAD0;
    tick();
    wait_bt("rm_bt");
    tick();
    tick();
    chk("rm_read_before", READ, 1);
    rst = 1'b1;
    tick();
    chk("rm_ctl", {READ, WRITE, BEGINTRANSFER, LOCK, done, err, busy}, 0);
    chk("rm_addr", ADDRESS, 0);
    rst = 1'b0;
    stuck_en = 1'b0;
    tick();
    single_read();
    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);

    // Fixed priority: ch0 re-requests on each done and keeps winning
    start_b = 3'b111;
    wdata_b = {32'hC2, 32'hC1, 32'hC0};
    addr_b  = {32'h2, 32'h1, 32'h0};
    tick();
    restarts = 0;
    b_log.delete();
    for (int i = 0; i < 80 && b_log.size() < 6; i++) begin
      for (int c = 0; c < 3; c++) if (done_b[c]) b_log.push_back(c);
      if (done_b[0] && restarts < 3) begin
        start_b[0] = 1'b1;
        restarts++;
      end
      tick();
    end
    chk("fp_count", b_log.size(), 6);
    for (int k = 0; k < 6; k++) if (k < b_log.size()) chk("fp_order", b_log[k], exp_b[k]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_mm_multi_master.md
Name: avalon_mm_multi_master

Overview:
Parametrised successor to the per-port Avalon-MM master. It merges CHANNELS independent requesters (e.g. instruction fetch, data, debug bridge) onto one Avalon-MM master port. Each channel has its own start/done handshake and request buffer. A round-robin or fixed-priority arbiter selects the channel to serve, and the block adds bus locking and a wait-request timeout with error report.

Parameters:
CHANNELS, 3, number of requesting channels (2..8)
WIDTH, 32, data width
ADDR_WIDTH, 32, address width
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
TIMEOUT, 0, max cycles WAITREQUEST may stay high; 0 = disabled

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
start  in  CHANNELS  per-channel one-cycle request pulse
rnw  in  CHANNELS  per-channel 1 = read, 0 = write, sampled with start
lock_req  in  CHANNELS  per-channel lock request, sampled with start
address_to_access  in  CHANNELS*ADDR_WIDTH  per-channel address, channel i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
data_to_write  in  CHANNELS*WIDTH  per-channel write data, same slicing
busy  out  CHANNELS  channel has a pending or active request
done  out  CHANNELS  one-cycle completion pulse
err  out  CHANNELS  valid with done; 1 = timed out
data_read  out  WIDTH  read data, valid in the done cycle
ADDRESS  out  ADDR_WIDTH  Avalon address
BEGINTRANSFER  out  1  first cycle of a transfer
READ  out  1  Avalon read
WRITE  out  1  Avalon write
WRITEDATA  out  WIDTH  Avalon write data
LOCK  out  1  Avalon lock
READDATA  in  WIDTH  Avalon read data
WAITREQUEST  in  1  Avalon wait request

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous and active-high.
- Reset values: all outputs are 0, all pending bits are cleared, lock owner is cleared, RR pointer = CHANNELS-1, FSM = IDLE.
- Reset mid-transfer: READ/WRITE drop on the next edge and no done is issued.
- Request buffer (per channel): on start[i] with busy[i] = 0, latch rnw, lock_req, address and data, and set pending[i]. busy[i] = pending[i] or active[i].
  - start[i] while busy[i] = 1 is ignored.
- Arbitration (IDLE state only): the eligible set is the pending channels.
  - If a lock owner is set, only the owner is eligible; other channels wait even while the owner is idle.
  - PRIORITY_MODE = 0: search from pointer+1 upward with wrap-around; the pointer is updated to the granted index.
  - PRIORITY_MODE = 1: grant the lowest pending index.
- FSM:
  - IDLE: if any channel is eligible, grant channel g, clear pending[g], register ADDRESS/WRITEDATA/READ or WRITE/LOCK, set BEGINTRANSFER = 1, go to XFER.
  - XFER: BEGINTRANSFER = 0 after its first cycle. Outputs stay stable while WAITREQUEST = 1.
    - WAITREQUEST = 0 sampled: deassert READ/WRITE/LOCK. On a read, register READDATA into data_read. Pulse done[g] with err[g] = 0 next cycle, go to IDLE.
    - TIMEOUT > 0 and the wait counter reaches TIMEOUT with WAITREQUEST still 1: abort. Deassert READ/WRITE, done[g] = 1, err[g] = 1, data_read = 0, lock owner cleared, go to IDLE.
- Timing: a zero-wait read takes start in C0, pending in C1, READ + BEGINTRANSFER in C2, done + data in C3. Each wait-state cycle adds 1. There is at least one idle bus cycle between consecutive transfers.
- Lock: the granted transfer with lock_req = 1 drives LOCK = 1 and makes g the lock owner. Completing an owner transfer with lock_req = 0 releases the lock; that transfer drives LOCK = 0.
- Simultaneous events:
  - start[g] in the same cycle as done[g] is accepted, because busy[g] is already 0 in the done cycle.
  - Multiple starts in one cycle are all buffered.
- data_read holds its value until the next read completes.
- Unused bus outputs: WRITEDATA = 0 during reads; ADDRESS keeps its last value in IDLE.

Test Plan:
- Single read, zero wait: ch1 start, rnw = 1, addr 0x1000, READDATA = 0xDEADBEEF -> READ and BEGINTRANSFER high in C2, ADDRESS = 0x1000, done[1] in C3, data_read = 0xDEADBEEF, err = 0.
- Round-robin fairness: ch0/1/2 write starts in the same cycle, repeated 3 times -> grant order 0,1,2,0,1,2,0,1,2. With PRIORITY_MODE = 1 and ch0 re-requesting in its done cycle, ch0 is served repeatedly while ch1 and ch2 wait.
- Wait states: WAITREQUEST high for 4 cycles on a write of 0x55AA to 0x20 -> ADDRESS, WRITEDATA and WRITE stable for 5 cycles, BEGINTRANSFER high 1 cycle, done 1 cycle after WAITREQUEST falls.
- Lock: ch2 locked write then unlocked read, with ch0 pending throughout -> LOCK = 1 on the first transfer, ch0 blocked until ch2's unlocked read completes, then ch0 is granted.
- Timeout: TIMEOUT = 8, WAITREQUEST stuck at 1 -> done[0] = 1, err[0] = 1, data_read = 0, READ low after 8 cycles, next pending channel served.
- Reset mid-transfer: RST during XFER -> all outputs 0 next cycle, busy = 0, no done; a start after reset behaves per scenario 1.
